div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned integer divider, instantiated inside the EX stage for DIV/DIVU.
- EX holds its start request and raises stallreq_from_ex to the stall controller while the divider is busy. The controller then freezes PC, IF/ID, ID/EX and EX (stall = 6'b001111) until ready_o.
- Radix-2 restoring algorithm: one quotient bit per cycle.
- Result is {remainder, quotient}, written to HI/LO.

Parameters:
- WIDTH, 32, operand width. Quotient and remainder are each WIDTH bits; result is 2*WIDTH bits.
- CNT_W, 6, iteration-counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
- opdata1_i  input  WIDTH  dividend; sampled at start
- opdata2_i  input  WIDTH  divisor; sampled at start
- start_i  input  1  division request; level, held high by EX until ready_o seen
- annul_i  input  1  abort in-flight division (branch-delay/flush)
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
- ready_o  output  1  result valid
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset, async: state=IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0, internal regs=0. Reset mid-division discards the operation.
- All outputs are registered except busy_o, which is decoded from state.
- States are IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON.
  - On entering ON: latch the magnitudes of both operands (two's-complement abs if signed_div_i, else raw), latch signed_div_i and both operand sign bits, set cnt=0, clear partial remainder.
  - Otherwise stay in IDLE with ready_o=0 and result_o=0.
- BYZERO: next cycle -> END with quotient=0 and remainder=0. No exception is raised.
- ON:
  - Each cycle: shift {rem, dividend} left 1, then trial-subtract the divisor magnitude.
  - If non-negative, keep the difference and set the quotient LSB=1; else restore and set the quotient LSB=0.
  - cnt increments each cycle. When cnt==WIDTH -> END.
  - annul_i=1 in ON -> IDLE immediately, cnt=0, no result.
- END:
  - Apply sign correction:
    - Signed: negate the quotient if the operand signs differ.
    - Signed: the remainder takes the dividend's sign (negated if the dividend was negative).
    - Unsigned: no correction.
  - result_o is updated and ready_o=1 on the cycle state is END.
  - Stay in END while start_i=1. When start_i=0 -> IDLE, ready_o=0, result_o=0.
- Latency, start sampled at edge N:
  - Normal: ready_o high from edge N+WIDTH+2 (34 cycles for WIDTH=32).
  - Divide-by-zero: ready_o high at N+2.
- Arithmetic rules:
  - Trial subtract is WIDTH+1 bits wide.
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps, no trap).
- Simultaneous start_i and annul_i in IDLE: annul wins, no start.
- annul_i in BYZERO or END is ignored.
- Operand changes after start are ignored; operands are latched.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE on a valid start with nonzero divisor, if |dividend| < |divisor| (unsigned compare of magnitudes) -> END directly with quotient=0, remainder=original dividend. ready_o high at N+2.
- Not defined: every nonzero-divisor operation takes the full WIDTH iterations.

Test Plan:
- Unsigned: DIVU 100 / 7, start held -> ready_o at 34 cycles after start, result_o={32'd2, 32'd14}; drop start -> next cycle ready_o=0, result_o=0.
- Signed: DIV -7 / 2 -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quo -3); DIV 7 / -2 -> {32'd1, 32'hFFFFFFFD}.
- Divide-by-zero: opdata2_i=0 -> ready_o at 2 cycles, result_o=0; wraparound: DIV 0x80000000 / 0xFFFFFFFF -> {0, 32'h80000000}.
- Annul: start 100/7, assert annul_i at iteration 10 -> busy_o=0 next cycle, ready_o never rises; a new start of 9/3 then gives {0, 3} after 34 cycles.
- Reset mid-operation: assert rst asynchronously at iteration 20 -> all outputs 0 immediately, state IDLE; with DIV_EARLY_OUT_EN, DIVU 5/9 -> ready_o at 2 cycles, result_o={32'd5, 32'd0}.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU, result {rem, quo}; ready_o at start+WIDTH+2 (start+2 for /0 or early-out).
// start_i is a held level: result stays valid until start_i drops. Optional DIV_EARLY_OUT_EN skips |a|<|b|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave div
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dsr_q;
  logic               sgn_q;
  logic               s1_q;
  logic               s2_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op1_abs = (div.signed_div_i && div.opdata1_i[WIDTH-1]) ? -div.opdata1_i : div.opdata1_i;
  assign op2_abs = (div.signed_div_i && div.opdata2_i[WIDTH-1]) ? -div.opdata2_i : div.opdata2_i;

  // dvd_q shifts out dividend bits at the top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dsr_q};
    rem_d   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_d   = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
    quo_fix = (sgn_q && (s1_q ^ s2_q)) ? -dvd_q : dvd_q;
    rem_fix = (sgn_q && s1_q) ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          cnt_q    <= '0;
          if (div.start_i && !div.annul_i) begin
            sgn_q <= div.signed_div_i;
            s1_q  <= div.opdata1_i[WIDTH-1];
            s2_q  <= div.opdata2_i[WIDTH-1];
            dvd_q <= op1_abs;
            dsr_q <= op2_abs;
            rem_q <= '0;
            if (div.opdata2_i == '0) begin
              state_q <= BYZERO;
            end
`ifdef DIV_EARLY_OUT_EN
            // Preloading the finished count reuses ON's exit cycle, keeping the /0 latency.
            else if (op1_abs < op2_abs) begin
              rem_q   <= op1_abs;
              dvd_q   <= '0;
              cnt_q   <= CNT_MAX;
              state_q <= ON;
            end
`endif
            else begin
              state_q <= ON;
            end
          end
        end
        BYZERO: begin
          rem_q   <= '0;
          dvd_q   <= '0;
          state_q <= END;
        end
        ON: begin
          if (div.annul_i) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= END;
          end else begin
            rem_q <= rem_d;
            dvd_q <= quo_d;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        END: begin
          if (div.start_i) begin
            ready_q  <= 1'b1;
            result_q <= {rem_fix, quo_fix};
          end else begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div.result_o = result_q;
  assign div.ready_o  = ready_q;
  assign div.busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {rem, quo} and latency queued at start, checked at ready_o.
module tb_div_unit;
  localparam int WIDTH = 32;
  localparam int TMO   = 100;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [2*WIDTH-1:0] exp_res_q[$];
  int                 exp_lat_q[$];

  div_unit_if #(.WIDTH(WIDTH)) div_if ();

  div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .div (div_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] model_res(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int model_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (((s && a[31]) ? -a : a) < ((s && b[31]) ? -b : b)) return 2;
`endif
    return 34;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    div_if.signed_div_i = s;
    div_if.opdata1_i    = a;
    div_if.opdata2_i    = b;
    div_if.start_i      = 1'b1;
    exp_res_q.push_back(model_res(s, a, b));
    exp_lat_q.push_back(model_lat(s, a, b));
  endtask

  // Returns cycles from the sampling edge to ready_o; operands are scrambled once sampled.
  task automatic wait_ready(output int lat, output logic busy_n, output logic [63:0] res);
    step();
    lat = 0;
    busy_n = div_if.busy_o;
    div_if.opdata1_i    = $urandom;
    div_if.opdata2_i    = $urandom;
    div_if.signed_div_i = ~div_if.signed_div_i;
    while (!div_if.ready_o && lat < TMO) begin
      step();
      lat++;
    end
    res = div_if.result_o;
  endtask

  task automatic release_op();
    div_if.start_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i = '0;
    div_if.opdata2_i = '0;
    div_if.start_i = 1'b0;
    div_if.annul_i = 1'b0;
    #12;
    n_cmp++; if (div_if.result_o !== 64'd0) begin n_err++; $display("FAIL reset_result got=%h want=0", div_if.result_o); end
    n_cmp++; if (div_if.ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", div_if.ready_o); end
    n_cmp++; if (div_if.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", div_if.busy_o); end
    #5 rst = 1'b0;
    step();
    n_cmp++; if (div_if.busy_o !== 1'b0 || div_if.ready_o !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset busy=%b ready=%b want 0/0", div_if.busy_o, div_if.ready_o);
    end
  endtask

  task automatic test_unsigned();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(lat, busy_n, res);
    er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
    n_cmp++; if (busy_n !== 1'b1) begin n_err++; $display("FAIL divu_busy got=%b want=1", busy_n); end
    n_cmp++; if (lat != el) begin n_err++; $display("FAIL divu_latency got=%0d want=%0d", lat, el); end
    n_cmp++; if (res !== er || er !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_100_7 got=%h want=%h", res, {32'd2, 32'd14}); end
    step();
    n_cmp++; if (div_if.ready_o !== 1'b1 || div_if.result_o !== er) begin
      n_err++; $display("FAIL divu_hold ready=%b result=%h want 1/%h", div_if.ready_o, div_if.result_o, er);
    end
    release_op();
    n_cmp++; if (div_if.ready_o !== 1'b0 || div_if.result_o !== 64'd0 || div_if.busy_o !== 1'b0) begin
      n_err++; $display("FAIL divu_release ready=%b result=%h busy=%b want 0/0/0", div_if.ready_o, div_if.result_o, div_if.busy_o);
    end
  endtask

  task automatic test_signed();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    logic [31:0] a_tab [2] = '{32'hFFFF_FFF9, 32'd7};
    logic [31:0] b_tab [2] = '{32'd2, 32'hFFFF_FFFE};
    logic [63:0] k_tab [2] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD}};
    for (int i = 0; i < 2; i++) begin
      start_op(1'b1, a_tab[i], b_tab[i]);
      wait_ready(lat, busy_n, res);
      er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
      n_cmp++; if (lat != el) begin n_err++; $display("FAIL div_signed_lat[%0d] got=%0d want=%0d", i, lat, el); end
      n_cmp++; if (res !== er || er !== k_tab[i]) begin n_err++; $display("FAIL div_signed[%0d] got=%h want=%h", i, res, k_tab[i]); end
      release_op();
    end
  endtask

  task automatic test_div_zero();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    for (int i = 0; i < 2; i++) begin
      start_op(i[0], (i == 0) ? 32'd5 : 32'hFFFF_FFFB, 32'd0);
      wait_ready(lat, busy_n, res);
      er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
      n_cmp++; if (lat != 2 || lat != el) begin n_err++; $display("FAIL div_zero_lat[%0d] got=%0d want=2", i, lat); end
      n_cmp++; if (res !== 64'd0 || div_if.ready_o !== 1'b1) begin n_err++; $display("FAIL div_zero_res[%0d] got=%h ready=%b want 0/1", i, res, div_if.ready_o); end
      release_op();
    end
  endtask

  task automatic test_wrap();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(lat, busy_n, res);
    er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
    n_cmp++; if (lat != el) begin n_err++; $display("FAIL wrap_lat got=%0d want=%0d", lat, el); end
    n_cmp++; if (res !== {32'd0, 32'h8000_0000} || res !== er) begin n_err++; $display("FAIL wrap got=%h want=%h", res, {32'd0, 32'h8000_0000}); end
    release_op();
  endtask

  task automatic test_annul();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    int seen;
    div_if.annul_i = 1'b1;
    start_op(1'b0, 32'd100, 32'd7);
    void'(exp_res_q.pop_back()); void'(exp_lat_q.pop_back());
    step();
    n_cmp++; if (div_if.busy_o !== 1'b0) begin n_err++; $display("FAIL annul_start_idle busy got=%b want=0", div_if.busy_o); end
    div_if.annul_i = 1'b0;
    step();
    for (int i = 0; i < 10; i++) step();
    div_if.annul_i = 1'b1;
    div_if.start_i = 1'b0;
    step();
    n_cmp++; if (div_if.busy_o !== 1'b0) begin n_err++; $display("FAIL annul_busy got=%b want=0", div_if.busy_o); end
    div_if.annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (div_if.ready_o === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL annul_no_ready got=%0d ready cycles want=0", seen); end
    start_op(1'b0, 32'd9, 32'd3);
    wait_ready(lat, busy_n, res);
    er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
    n_cmp++; if (lat != el) begin n_err++; $display("FAIL annul_restart_lat got=%0d want=%0d", lat, el); end
    n_cmp++; if (res !== {32'd0, 32'd3} || res !== er) begin n_err++; $display("FAIL annul_restart got=%h want=%h", res, {32'd0, 32'd3}); end
    release_op();
  endtask

  task automatic test_reset_mid();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    start_op(1'b0, 32'd100, 32'd7);
    void'(exp_res_q.pop_back()); void'(exp_lat_q.pop_back());
    step();
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (div_if.busy_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy got=%b want=1", div_if.busy_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (div_if.busy_o !== 1'b0 || div_if.ready_o !== 1'b0 || div_if.result_o !== 64'd0) begin
      n_err++; $display("FAIL mid_reset busy=%b ready=%b result=%h want 0/0/0", div_if.busy_o, div_if.ready_o, div_if.result_o);
    end
    div_if.start_i = 1'b0;
    #1 rst = 1'b0;
    step();
    start_op(1'b0, 32'd7, 32'd2);
    wait_ready(lat, busy_n, res);
    er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
    n_cmp++; if (lat != el || res !== er || er !== {32'd1, 32'd3}) begin
      n_err++; $display("FAIL post_reset_op got=%h lat=%0d want=%h lat=%0d", res, lat, {32'd1, 32'd3}, el);
    end
    release_op();
  endtask

  task automatic test_early_out();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    start_op(1'b0, 32'd5, 32'd9);
    wait_ready(lat, busy_n, res);
    er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
    n_cmp++; if (lat != el) begin n_err++; $display("FAIL early_lat got=%0d want=%0d", lat, el); end
    n_cmp++; if (res !== {32'd5, 32'd0} || res !== er) begin n_err++; $display("FAIL early_res got=%h want=%h", res, {32'd5, 32'd0}); end
    release_op();
    start_op(1'b1, 32'hFFFF_FFFD, 32'd8);
    wait_ready(lat, busy_n, res);
    er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
    n_cmp++; if (lat != el || res !== {32'hFFFF_FFFD, 32'd0} || res !== er) begin
      n_err++; $display("FAIL early_signed got=%h lat=%0d want=%h lat=%0d", res, lat, {32'hFFFF_FFFD, 32'd0}, el);
    end
    release_op();
  endtask

  task automatic test_back_to_back();
    int lat; logic busy_n; logic [63:0] res; logic [63:0] er; int el;
    logic [31:0] a; logic [31:0] b; logic s;
    for (int i = 0; i < 8; i++) begin
      s = i[0];
      a = $urandom;
      b = (i == 3) ? 32'd0 : ($urandom >> (i * 3));
      if (i != 3 && b == 32'd0) b = 32'd13;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      start_op(s, a, b);
      wait_ready(lat, busy_n, res);
      er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
      n_cmp++; if (lat != el || res !== er) begin
        n_err++; $display("FAIL b2b[%0d] s=%b a=%h b=%h got=%h lat=%0d want=%h lat=%0d", i, s, a, b, res, lat, er, el);
      end
      release_op();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_wrap();
    test_annul();
    test_reset_mid();
    test_early_out();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
